// File: rtl/busctrl_pkg.sv
// Shared definitions for the internal bus controller: FSM encoding,
// the latched transaction record and the data returned on a timeout.
package busctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } busctrl_state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic       rd;
    } busctrl_req_t;

    localparam logic [7:0] BUSCTRL_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/ip_busctrl_decode.sv
// Combinational address decoder: per-device I/O and memory-page hits,
// chip selects, and the lowest-index device of the active cycle type.
module ip_busctrl_decode #(
    parameter int          NUM_DEV      = 4,
    parameter logic [31:0] DEV_IO_BASE  = 32'h00000000,
    parameter logic [31:0] DEV_IO_MASK  = 32'h00000000,
    parameter logic [15:0] DEV_MEM_PAGE = 16'h0000
) (
    input  logic [15:0]        bus_address,
    input  logic               bus_io,
    output logic [NUM_DEV-1:0] hit,
    output logic               io_cs,
    output logic               mem_cs,
    output logic [1:0]         sel_idx
);

    logic [NUM_DEV-1:0] io_hit;
    logic [NUM_DEV-1:0] mem_hit;
    logic [1:0]         page;

    assign page = bus_address[15:14];

    for (genvar i = 0; i < NUM_DEV; i++) begin : g_dev
        logic [7:0] base;
        logic [7:0] mask;
        assign base = DEV_IO_BASE[8*i +: 8];
        assign mask = DEV_IO_MASK[8*i +: 8];
        // A zero mask would match every address, so it means "no I/O window".
        assign io_hit[i]  = (mask != 8'h00) && (((bus_address[7:0] ^ base) & mask) == 8'h00);
        assign mem_hit[i] = DEV_MEM_PAGE[4*i + int'(page)];
    end

    assign io_cs  = |io_hit;
    assign mem_cs = |mem_hit;
    assign hit    = bus_io ? io_hit : mem_hit;

    always_comb begin
        sel_idx = 2'd0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (hit[i]) sel_idx = 2'(i);
        end
    end

endmodule

// File: rtl/ip_busctrl.sv
// Internal bus controller: routes one latched bus request to a decoded
// device, strobes it once, and waits for its ack or a timeout.
module ip_busctrl
    import busctrl_pkg::*;
#(
    parameter int          NUM_DEV      = 4,
    parameter logic [31:0] DEV_IO_BASE  = 32'h00000000,
    parameter logic [31:0] DEV_IO_MASK  = 32'h00000000,
    parameter logic [15:0] DEV_MEM_PAGE = 16'h0000,
    parameter int          TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [15:0]          bus_address,
    input  logic [7:0]           bus_write_data,
    input  logic                 bus_read,
    input  logic                 bus_write,
    input  logic                 bus_io,
    input  logic                 bus_memory,
    output logic                 bus_io_cs,
    output logic                 bus_memory_cs,
    output logic                 bus_read_ready,
    output logic [7:0]           bus_read_data,
    output logic [NUM_DEV-1:0]   dev_rd,
    output logic [NUM_DEV-1:0]   dev_wr,
    output logic [15:0]          dev_address,
    output logic [7:0]           dev_wdata,
    input  logic [NUM_DEV-1:0]   dev_ack,
    input  logic [8*NUM_DEV-1:0] dev_rdata,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    busctrl_state_t     state;
    busctrl_req_t       req_q;
    logic [7:0]         cnt;
    logic [NUM_DEV-1:0] dec_hit;
    logic [1:0]         dec_idx;
    logic [NUM_DEV-1:0] dec_oh;
    logic               req;
    logic [7:0]         sel_rdata;

    ip_busctrl_decode #(
        .NUM_DEV      (NUM_DEV),
        .DEV_IO_BASE  (DEV_IO_BASE),
        .DEV_IO_MASK  (DEV_IO_MASK),
        .DEV_MEM_PAGE (DEV_MEM_PAGE)
    ) u_decode (
        .bus_address (bus_address),
        .bus_io      (bus_io),
        .hit         (dec_hit),
        .io_cs       (bus_io_cs),
        .mem_cs      (bus_memory_cs),
        .sel_idx     (dec_idx)
    );

    assign req       = bus_read | bus_write;
    assign dec_oh    = NUM_DEV'(1) << dec_idx;
    assign sel_rdata = dev_rdata[{req_q.sel, 3'b000} +: 8];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state          <= ST_IDLE;
            req_q          <= '0;
            cnt            <= '0;
            dev_rd         <= '0;
            dev_wr         <= '0;
            dev_address    <= '0;
            dev_wdata      <= '0;
            bus_read_ready <= 1'b1;
            bus_read_data  <= BUSCTRL_TIMEOUT_DATA;
            err_timeout    <= 1'b0;
            err_overrun    <= 1'b0;
        end else begin
            dev_rd      <= '0;
            dev_wr      <= '0;
            err_timeout <= 1'b0;
            // The in-flight transaction owns the bus; late requests are only flagged.
            err_overrun <= req && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (req && (bus_io || bus_memory) && (|dec_hit)) begin
                        state       <= ST_ISSUE;
                        req_q.sel   <= dec_idx;
                        req_q.rd    <= bus_read;
                        dev_address <= bus_address;
                        dev_wdata   <= bus_write_data;
                        if (bus_read) begin
                            bus_read_ready <= 1'b0;
                            dev_rd         <= dec_oh;
                        end else begin
                            dev_wr <= dec_oh;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    if (dev_ack[req_q.sel]) begin
                        state <= ST_DONE;
                        if (req_q.rd) begin
                            bus_read_data  <= sel_rdata;
                            bus_read_ready <= 1'b1;
                        end
                    end else if (cnt == 8'(TIMEOUT)) begin
                        state       <= ST_DONE;
                        err_timeout <= 1'b1;
                        if (req_q.rd) begin
                            bus_read_data  <= BUSCTRL_TIMEOUT_DATA;
                            bus_read_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_busctrl.sv
// Directed bench for ip_busctrl: table-driven decode checks plus
// hand-written transaction sequences with cycle-exact expectations.
module tb_ip_busctrl;

    localparam int NUM_DEV = 4;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] bus_address = '0;
    logic [7:0]  bus_write_data = '0;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_io = 1'b0;
    logic        bus_memory = 1'b0;
    logic        bus_io_cs;
    logic        bus_memory_cs;
    logic        bus_read_ready;
    logic [7:0]  bus_read_data;
    logic [3:0]  dev_rd;
    logic [3:0]  dev_wr;
    logic [15:0] dev_address;
    logic [7:0]  dev_wdata;
    logic [3:0]  dev_ack = '0;
    logic [31:0] dev_rdata = '0;
    logic        err_timeout;
    logic        err_overrun;

    int checks = 0;
    int failures = 0;
    int rd_seen [4];
    int wr_seen [4];

    // dev0: I/O 0x98/0x99; dev1: I/O 0x40-0x4F, page 2; dev2: page 1 only;
    // dev3: I/O 0x44-0x47, pages 2 and 3.
    ip_busctrl #(
        .NUM_DEV      (NUM_DEV),
        .DEV_IO_BASE  (32'h44004098),
        .DEV_IO_MASK  (32'hFC00F0FE),
        .DEV_MEM_PAGE (16'hC240),
        .TIMEOUT      (8)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .bus_address    (bus_address),
        .bus_write_data (bus_write_data),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_io         (bus_io),
        .bus_memory     (bus_memory),
        .bus_io_cs      (bus_io_cs),
        .bus_memory_cs  (bus_memory_cs),
        .bus_read_ready (bus_read_ready),
        .bus_read_data  (bus_read_data),
        .dev_rd         (dev_rd),
        .dev_wr         (dev_wr),
        .dev_address    (dev_address),
        .dev_wdata      (dev_wdata),
        .dev_ack        (dev_ack),
        .dev_rdata      (dev_rdata),
        .err_timeout    (err_timeout),
        .err_overrun    (err_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) begin
            rd_seen[i] = 0;
            wr_seen[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dev_rd[i]) rd_seen[i]++;
            if (dev_wr[i]) wr_seen[i]++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        io_cs;
        logic        mem_cs;
    } dec_vec_t;

    dec_vec_t vecs [8];
    int       ready_lo;
    int       rd_base [4];
    int       wr_base [4];

    initial begin
        vecs[0] = '{16'h0099, 1'b1, 1'b0};
        vecs[1] = '{16'h0098, 1'b1, 1'b0};
        vecs[2] = '{16'h009A, 1'b0, 1'b0};
        vecs[3] = '{16'h4045, 1'b1, 1'b1};
        vecs[4] = '{16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'hC04F, 1'b1, 1'b1};
        vecs[6] = '{16'h4050, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(bus_read_ready), 32'h1);
        chk("rst_rdata", 32'(bus_read_data), 32'hFF);
        chk("rst_dev_rd", 32'(dev_rd), 32'h0);
        chk("rst_dev_wr", 32'(dev_wr), 32'h0);
        chk("rst_dev_address", 32'(dev_address), 32'h0);
        chk("rst_errors", 32'({err_timeout, err_overrun}), 32'h0);
        cyc();
        n_reset = 1'b1;
        cyc();

        // Combinational decode table
        for (int i = 0; i < 8; i++) begin
            bus_address = vecs[i].addr;
            #1;
            chk($sformatf("dec_io_cs[%0h]", vecs[i].addr), 32'(bus_io_cs), 32'(vecs[i].io_cs));
            chk($sformatf("dec_mem_cs[%0h]", vecs[i].addr), 32'(bus_memory_cs), 32'(vecs[i].mem_cs));
        end
        cyc();

        // I/O read to dev0, ack two cycles into WAIT
        dev_rdata = 32'hA1B2C35A;
        bus_address = 16'h0099; bus_io = 1'b1; bus_memory = 1'b0; bus_read = 1'b1;
        cyc();
        bus_read = 1'b0;
        chk("s1_ready_t1", 32'(bus_read_ready), 32'h0);
        chk("s1_dev_rd_t1", 32'(dev_rd), 32'h1);
        chk("s1_dev_address", 32'(dev_address), 32'h0099);
        cyc();
        chk("s1_dev_rd_t2", 32'(dev_rd), 32'h0);
        cyc();
        cyc();
        chk("s1_ready_t4", 32'(bus_read_ready), 32'h0);
        dev_ack = 4'b0001;
        cyc();
        dev_ack = 4'b0000;
        chk("s1_ready_t5", 32'(bus_read_ready), 32'h1);
        chk("s1_rdata", 32'(bus_read_data), 32'h5A);
        chk("s1_rd_pulses", 32'(rd_seen[0]), 32'h1);
        cyc();

        // Memory write to page 1 (dev2)
        bus_address = 16'h4000; bus_write_data = 8'hC3; bus_io = 1'b0; bus_memory = 1'b1; bus_write = 1'b1;
        cyc();
        bus_write = 1'b0;
        chk("s2_dev_wr_t1", 32'(dev_wr), 32'h4);
        chk("s2_dev_rd_t1", 32'(dev_rd), 32'h0);
        chk("s2_dev_address", 32'(dev_address), 32'h4000);
        chk("s2_dev_wdata", 32'(dev_wdata), 32'hC3);
        chk("s2_ready_t1", 32'(bus_read_ready), 32'h1);
        cyc();
        chk("s2_dev_wr_t2", 32'(dev_wr), 32'h0);
        dev_ack = 4'b0100;
        cyc();
        dev_ack = 4'b0000;
        chk("s2_ready_done", 32'(bus_read_ready), 32'h1);
        chk("s2_rdata_held", 32'(bus_read_data), 32'h5A);
        chk("s2_wr_pulses", 32'(wr_seen[2]), 32'h1);
        cyc();

        // Read to dev3 page 3 that never acks: timeout after 8 WAIT cycles
        bus_address = 16'hC000; bus_read = 1'b1;
        cyc();
        bus_read = 1'b0;
        chk("s3_dev_rd_t1", 32'(dev_rd), 32'h8);
        ready_lo = (bus_read_ready == 1'b0) ? 1 : 0;
        for (int j = 2; j <= 10; j++) begin
            cyc();
            if (bus_read_ready == 1'b0 && err_timeout == 1'b0) ready_lo++;
        end
        chk("s3_ready_low_cycles", 32'(ready_lo), 32'd10);
        cyc();
        chk("s3_ready_t11", 32'(bus_read_ready), 32'h1);
        chk("s3_err_timeout", 32'(err_timeout), 32'h1);
        chk("s3_rdata", 32'(bus_read_data), 32'hFF);
        cyc();
        chk("s3_err_timeout_pulse", 32'(err_timeout), 32'h0);

        // Overlapping I/O hits on dev1/dev3, overrun during WAIT, stray ack
        for (int i = 0; i < 4; i++) begin
            rd_base[i] = rd_seen[i];
            wr_base[i] = wr_seen[i];
        end
        dev_rdata = 32'h11CC7700;
        bus_address = 16'h0045; bus_io = 1'b1; bus_memory = 1'b0; bus_read = 1'b1;
        cyc();
        bus_read = 1'b0;
        chk("s4_dev_rd_t1", 32'(dev_rd), 32'h2);
        cyc();
        bus_write = 1'b1;
        cyc();
        bus_write = 1'b0;
        chk("s4_err_overrun", 32'(err_overrun), 32'h1);
        chk("s4_no_wr_strobe", 32'(dev_wr), 32'h0);
        cyc();
        chk("s4_err_overrun_pulse", 32'(err_overrun), 32'h0);
        dev_ack = 4'b1000;
        cyc();
        chk("s4_stray_ack_ignored", 32'(bus_read_ready), 32'h0);
        dev_ack = 4'b0010;
        cyc();
        dev_ack = 4'b0000;
        chk("s4_ready", 32'(bus_read_ready), 32'h1);
        chk("s4_rdata", 32'(bus_read_data), 32'h77);
        chk("s4_dev3_rd_pulses", 32'(rd_seen[3] - rd_base[3]), 32'h0);
        chk("s4_dev1_rd_pulses", 32'(rd_seen[1] - rd_base[1]), 32'h1);
        chk("s4_wr_pulses", 32'((wr_seen[0] + wr_seen[1] + wr_seen[2] + wr_seen[3])
                                - (wr_base[0] + wr_base[1] + wr_base[2] + wr_base[3])), 32'h0);
        cyc();

        // Request to an address with no decode hit
        for (int i = 0; i < 4; i++) rd_base[i] = rd_seen[i];
        bus_address = 16'h009A; bus_io = 1'b1; bus_read = 1'b1;
        cyc();
        bus_read = 1'b0;
        chk("s5_no_strobe", 32'(dev_rd), 32'h0);
        chk("s5_ready", 32'(bus_read_ready), 32'h1);
        cyc();
        chk("s5_no_overrun", 32'(err_overrun), 32'h0);
        chk("s5_rd_pulses", 32'((rd_seen[0] + rd_seen[1] + rd_seen[2] + rd_seen[3])
                                - (rd_base[0] + rd_base[1] + rd_base[2] + rd_base[3])), 32'h0);

        // Reset during WAIT, then a late ack
        bus_address = 16'h0099; bus_write_data = 8'h3C; bus_read = 1'b1;
        cyc();
        bus_read = 1'b0;
        cyc();
        chk("s6_in_wait_ready", 32'(bus_read_ready), 32'h0);
        n_reset = 1'b0;
        #1;
        chk("s6_rst_ready", 32'(bus_read_ready), 32'h1);
        chk("s6_rst_rdata", 32'(bus_read_data), 32'hFF);
        chk("s6_rst_dev_address", 32'(dev_address), 32'h0);
        chk("s6_rst_dev_wdata", 32'(dev_wdata), 32'h0);
        cyc();
        n_reset = 1'b1;
        dev_rdata = 32'h00000012;
        dev_ack = 4'b0001;
        cyc();
        dev_ack = 4'b0000;
        chk("s6_late_ack_ready", 32'(bus_read_ready), 32'h1);
        chk("s6_late_ack_rdata", 32'(bus_read_data), 32'hFF);
        cyc();
        chk("s6_late_ack_no_strobe", 32'({dev_rd, dev_wr}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
